// File: rtl/sequenciador_pc.sv
// sequenciador_pc: program-counter sequencer for the single-cycle lab CPU.
// Owns the PC register, selects the next address (jump > jump-register >
// taken branch > halt/input hold > increment) and runs the RUN / WAIT_IN /
// HALTED stall machine.
// Optional feature macro: SEQ_PC_INSTR_COUNT_EN adds the o_instr_count output,
// a count of the edges at which the PC was loaded.
module sequenciador_pc #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_jump,
    input  logic                  i_jump_reg,
    input  logic                  i_branch,
    input  logic                  i_branch_cond,
    input  logic                  i_halt,
    input  logic                  i_input_req,
    input  logic                  i_input_ack,
    input  logic                  i_resume,
    input  logic [DATA_WIDTH-1:0] i_target,
    input  logic [DATA_WIDTH-1:0] i_reg_target,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus1,
    output logic [1:0]            o_state,
    output logic                  o_stall,
`ifdef SEQ_PC_INSTR_COUNT_EN
    output logic [31:0]           o_instr_count,
`endif
    output logic                  o_input_latch
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_WAIT_IN = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DATA_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   w_pc_next;
    logic [DATA_WIDTH-1:0]   w_pc_inc;
    logic                    r_ack_prev;
    logic                    w_ack_edge;
    logic                    w_pc_load;
    logic                    w_input_latch;

    // The confirm button must see a fresh rising edge; a level held over
    // from before WAIT_IN was entered does not count.
    assign w_ack_edge = i_input_ack & ~r_ack_prev;
    assign w_pc_inc   = r_pc + 1'b1;

    // State register, PC and button history; reset overrides everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_ADDR;
            r_ack_prev <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ack_prev <= i_input_ack;
        end
    end

    // Next-state / next-PC selection with fixed strobe priority in RUN.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pc_load     = 1'b0;
        w_input_latch = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_pc_load = 1'b1;
                if (i_jump) begin
                    w_pc_next = i_target;
                end else if (i_jump_reg) begin
                    w_pc_next = i_reg_target;
                end else if (i_branch && i_branch_cond) begin
                    w_pc_next = i_target;
                end else if (i_halt) begin
                    w_pc_load    = 1'b0;
                    w_state_next = ST_HALTED;
                end else if (i_input_req) begin
                    w_pc_load    = 1'b0;
                    w_state_next = ST_WAIT_IN;
                end else begin
                    w_pc_next = w_pc_inc;
                end
            end
            ST_WAIT_IN: begin
                if (w_ack_edge) begin
                    // The switch value is written at the same edge the PC advances.
                    w_input_latch = ~i_reset;
                    w_pc_load     = 1'b1;
                    w_pc_next     = w_pc_inc;
                    w_state_next  = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    w_pc_load    = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

`ifdef SEQ_PC_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    // Counts PC loads; frozen while stalled, wraps naturally at 2^32.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_instr_count <= '0;
        end else if (w_pc_load) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign o_instr_count = r_instr_count;
`endif

    assign o_pc          = r_pc;
    assign o_pc_plus1    = w_pc_inc;
    assign o_state       = r_state;
    assign o_stall       = (r_state != ST_RUN);
    assign o_input_latch = w_input_latch;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Self-checking bench for sequenciador_pc. Expected {pc, state, stall} words
// are queued when stimulus is driven and popped after the clock edge.
module tb_sequenciador_pc;

    logic        clk = 1'b0;
    logic        reset, jump, jump_reg, branch, branch_cond;
    logic        halt, input_req, input_ack, resume;
    logic [31:0] target, reg_target;
    logic [31:0] o_pc, o_pc_plus1;
    logic [1:0]  o_state;
    logic        o_stall, o_input_latch;
`ifdef SEQ_PC_INSTR_COUNT_EN
    logic [31:0] o_instr_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [34:0] q_exp[$];
    logic [34:0] exp_word;
    logic [34:0] got_word;

    always #5 clk = ~clk;

    sequenciador_pc #(.DATA_WIDTH(32), .RESET_ADDR(32'h0)) dut (
        .i_clock      (clk),
        .i_reset      (reset),
        .i_jump       (jump),
        .i_jump_reg   (jump_reg),
        .i_branch     (branch),
        .i_branch_cond(branch_cond),
        .i_halt       (halt),
        .i_input_req  (input_req),
        .i_input_ack  (input_ack),
        .i_resume     (resume),
        .i_target     (target),
        .i_reg_target (reg_target),
        .o_pc         (o_pc),
        .o_pc_plus1   (o_pc_plus1),
        .o_state      (o_state),
        .o_stall      (o_stall),
`ifdef SEQ_PC_INSTR_COUNT_EN
        .o_instr_count(o_instr_count),
`endif
        .o_input_latch(o_input_latch)
    );

    function automatic logic [34:0] mk(input logic [31:0] pc, input logic [1:0] st);
        return {pc, st, (st != 2'b00)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        jump = 0; jump_reg = 0; branch = 0; branch_cond = 0;
        halt = 0; input_req = 0; resume = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_strobes(); input_ack = 0; target = 0; reg_target = 0;
        for (int i = 0; i < 2; i++) begin
            q_exp.push_back(mk(32'h0, 2'b00));
            tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word || o_input_latch !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h latch=%b exp=%h latch=0", i, got_word, o_input_latch, exp_word);
            end
        end
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            q_exp.push_back(mk(i, 2'b00));
            tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word || o_input_latch !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle got=%h latch=%b exp=%h latch=0", got_word, o_input_latch, exp_word);
            end
        end
    endtask

    task automatic test_priority();
        // {jump, jump_reg, branch, cond, target, reg_target, expected pc}
        logic [3:0]  str[5]  = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b0100};
        logic [31:0] tgt[5]  = '{32'h5, 32'h40, 32'h99, 32'h10, 32'h77};
        logic [31:0] rtg[5]  = '{32'h0, 32'h80, 32'h0, 32'h0, 32'h80};
        logic [31:0] epc[5]  = '{32'h5, 32'h40, 32'h41, 32'h10, 32'h80};
        for (int i = 0; i < 5; i++) begin
            {jump, jump_reg, branch, branch_cond} = str[i];
            target = tgt[i]; reg_target = rtg[i];
            q_exp.push_back(mk(epc[i], 2'b00));
            tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word || o_pc_plus1 !== epc[i] + 32'd1) begin
                failures++;
                $display("FAIL priority step=%0d got=%h plus1=%h exp=%h plus1=%h", i, got_word, o_pc_plus1, exp_word, epc[i] + 32'd1);
            end
        end
        clear_strobes();
    endtask

    task automatic test_wait_in();
        jump = 1; target = 32'h7; tick(); clear_strobes();
        input_req = 1; input_ack = 1;
        q_exp.push_back(mk(32'h7, 2'b01));
        tick(); input_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) input_ack = 0;
            if (i > 0) q_exp.push_back(mk(32'h7, 2'b01));
            if (i > 0) tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word || o_input_latch !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold i=%0d got=%h latch=%b exp=%h latch=0", i, got_word, o_input_latch, exp_word);
            end
        end
        tick();
        input_ack = 1; #1;
        checks++;
        if (o_input_latch !== 1'b1) begin
            failures++;
            $display("FAIL wait_latch got=%b exp=1", o_input_latch);
        end
        q_exp.push_back(mk(32'h8, 2'b00));
        tick();
        exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
        checks++;
        if (got_word !== exp_word || o_input_latch !== 1'b0) begin
            failures++;
            $display("FAIL wait_exit got=%h latch=%b exp=%h latch=0", got_word, o_input_latch, exp_word);
        end
        input_ack = 0;
    endtask

    task automatic test_halt();
        logic [31:0] cnt_frozen;
        jump = 1; target = 32'h9; tick(); clear_strobes();
        halt = 1;
        tick(); halt = 0;
        cnt_frozen = 0;
`ifdef SEQ_PC_INSTR_COUNT_EN
        cnt_frozen = o_instr_count;
`endif
        jump = 1; target = 32'h33;
        for (int i = 0; i < 10; i++) begin
            input_ack = i[0];
            q_exp.push_back(mk(32'h9, 2'b10));
            #1;
            checks++;
            if (o_input_latch !== 1'b0) begin
                failures++;
                $display("FAIL halt_latch i=%0d got=%b exp=0", i, o_input_latch);
            end
            tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word) begin
                failures++;
                $display("FAIL halt_hold i=%0d got=%h exp=%h", i, got_word, exp_word);
            end
        end
`ifdef SEQ_PC_INSTR_COUNT_EN
        checks++;
        if (o_instr_count !== cnt_frozen) begin
            failures++;
            $display("FAIL halt_count got=%0d exp=%0d", o_instr_count, cnt_frozen);
        end
`endif
        jump = 0; input_ack = 0; resume = 1;
        q_exp.push_back(mk(32'hA, 2'b00));
        tick(); resume = 0;
        exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
        checks++;
        if (got_word !== exp_word) begin
            failures++;
            $display("FAIL halt_resume got=%h exp=%h", got_word, exp_word);
        end
`ifdef SEQ_PC_INSTR_COUNT_EN
        checks++;
        if (o_instr_count !== cnt_frozen + 32'd1) begin
            failures++;
            $display("FAIL resume_count got=%0d exp=%0d", o_instr_count, cnt_frozen + 32'd1);
        end
`endif
    endtask

    task automatic test_wrap();
        jump = 1; target = 32'hFFFF_FFFF;
        q_exp.push_back(mk(32'hFFFF_FFFF, 2'b00));
        tick(); clear_strobes();
        exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
        checks++;
        if (got_word !== exp_word || o_pc_plus1 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_top got=%h plus1=%h exp=%h plus1=0", got_word, o_pc_plus1, exp_word);
        end
        q_exp.push_back(mk(32'h0, 2'b00));
        tick();
        exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
        checks++;
        if (got_word !== exp_word) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=%h", got_word, exp_word);
        end
    endtask

    task automatic test_reset_in_wait();
        jump = 1; target = 32'h20; tick(); clear_strobes();
        input_req = 1; input_ack = 0;
        tick(); input_req = 0;
        checks++;
        if (o_state !== 2'b01) begin
            failures++;
            $display("FAIL rst_wait_enter state=%b exp=01", o_state);
        end
        input_ack = 1; reset = 1; #1;
        checks++;
        if (o_input_latch !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_latch got=%b exp=0", o_input_latch);
        end
        q_exp.push_back(mk(32'h0, 2'b00));
        tick(); reset = 0; input_ack = 0;
        exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
        checks++;
        if (got_word !== exp_word) begin
            failures++;
            $display("FAIL rst_wait_exit got=%h exp=%h", got_word, exp_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        for (int i = 0; i < 8; i++) begin
            t = $urandom;
            jump = i[0]; jump_reg = ~i[0];
            target = i[0] ? t : ~t; reg_target = i[0] ? ~t : t;
            q_exp.push_back(mk(t, 2'b00));
            tick();
            exp_word = q_exp.pop_front(); got_word = {o_pc, o_state, o_stall};
            checks++;
            if (got_word !== exp_word) begin
                failures++;
                $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got_word, exp_word);
            end
        end
        clear_strobes();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_wait_in();
        test_halt();
        test_wrap();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
